wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Owns the single register-file write port at the end of the pipeline.
- Forms the pipeline write-back value (ALU result vs. load data, selected by wm2reg) and arbitrates it against a multi-cycle auxiliary unit, such as mult/div completion.
- The auxiliary unit's results are buffered in a small FIFO and drained in idle write-back slots.
- An optional starvation guard requests a one-cycle pipeline bubble.

Parameters:
- AUX_DEPTH, 4, auxiliary FIFO entries; power of two, minimum 2.
- MAX_WAIT, 8, cycles a non-empty FIFO head may wait before a bubble is requested (used only with WB_STARVE_EN).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- wwreg  in  1  pipeline WB-stage register-write enable.
- wrn  in  5  pipeline destination register.
- wr  in  32  pipeline ALU result.
- wdo  in  32  pipeline load data.
- wm2reg  in  1  0 selects wr, 1 selects wdo.
- aux_valid  in  1  auxiliary result offered.
- aux_rn  in  5  auxiliary destination register.
- aux_data  in  32  auxiliary result.
- aux_ready  out  1  FIFO can accept; registered, equals (count != AUX_DEPTH).
- rf_we  out  1  register-file write enable; registered.
- rf_wn  out  5  register-file write address; registered.
- rf_wd  out  32  register-file write data; registered.
- aux_pending  out  1  FIFO non-empty; registered.
- stall_req  out  1  one-cycle bubble request to the pipeline; registered.

Behaviour:
- Reset: rf_we=0, rf_wn=0, rf_wd=0, FIFO count/pointers=0, aux_ready=1, aux_pending=0, stall_req=0, wait counter=0.
- Reset mid-operation flushes the FIFO; buffered entries are lost, so the auxiliary unit must share rst.
- Pipeline write: pwr = wwreg && (wrn != 0). Data is wm2reg ? wdo : wr.
- Pipeline writes always win: write-back cannot stall.
- Grant is decided combinationally in cycle N; rf_* are registered at edge N+1. The pipeline write appears on rf_* with exactly 1 cycle of latency.
- Drain: if !pwr and the FIFO is non-empty, pop the head and drive it on rf_* next cycle.
- If neither source writes, rf_we=0 next cycle; rf_wn/rf_wd hold their previous values.
- Push: aux_valid && aux_ready.
  - An entry with aux_rn == 0 is accepted and discarded: no push, aux_ready unaffected.
  - A push in cycle N is eligible to pop no earlier than cycle N+1; there is no same-cycle FIFO bypass. Minimum aux latency is therefore 2 cycles to rf_we.
- Full boundary: aux_ready comes from the registered count. When full, no push occurs even if a pop happens in the same cycle. aux_ready rises the cycle after the pop.
- Simultaneous push and pop when non-empty and not full: count unchanged, pointers both advance, pointers wrap modulo AUX_DEPTH.
- Empty boundary: a pop is never attempted when count == 0.
- Ordering: FIFO entries drain strictly in arrival order.
- Register conflicts between aux results and later pipeline writes are resolved upstream: hazard logic must not issue a pipeline write to a register with a pending aux result. This block does not check for it.
- aux_pending = (count != 0), updated with count.

Optional Feature:
- Macro: WB_STARVE_EN.
- Defined:
  - The wait counter increments each cycle the FIFO is non-empty and the head is not popped.
  - It clears on a pop or when the FIFO is empty, and saturates at MAX_WAIT.
  - When the counter reaches MAX_WAIT, stall_req=1 for exactly one cycle and the counter clears.
  - Upstream responds by presenting wwreg=0 in the following cycle, which guarantees a drain.
- Undefined: stall_req is tied to 0, there is no counter, and aux entries may wait indefinitely under back-to-back pipeline writes.

Decomposition:
- Shared package: register-index width (5), data width (32), the r0 index constant, and the write-request struct {we, rn, data}.
- One sub-module: wb_aux_fifo, a synchronous FIFO with parameter AUX_DEPTH, outputs full/empty/count, and push/pop/flush ports.
- The arbiter top holds the select mux, grant logic, output registers and the starvation counter.

Test Plan:
- Reset check: assert rst with aux_valid=1 -> rf_we=0, aux_ready=1, aux_pending=0. No push occurs while rst=1.
- Pipeline select: wwreg=1, wrn=5, wr=0x11, wdo=0x22, wm2reg=0, then again with wm2reg=1 -> rf_we=1, rf_wn=5, rf_wd=0x11 then 0x22, each 1 cycle later. Repeat with wrn=0 -> rf_we=0.
- Aux drain: idle pipeline, push aux_rn=7, data 0xABCD at cycle N -> rf_we=1, rf_wn=7, rf_wd=0xABCD at N+2, and aux_pending drops.
- Priority/full: hold pwr=1 continuously and push 5 aux entries with AUX_DEPTH=4 -> aux_ready=0 after 4 pushes. Then drop wwreg -> entries drain in order, 1 per cycle.
- Starvation (WB_STARVE_EN, MAX_WAIT=8): FIFO non-empty with wwreg=1 every cycle -> stall_req pulses exactly once, 8 cycles after the head became pending. A bubble injected next cycle -> head written.
- Simultaneous push/pop with count=2 -> count stays 2 and pointer wrap is correct across 2×AUX_DEPTH operations.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its auxiliary FIFO.
// Imported by wb_aux_fifo and wb_write_arbiter.
package wb_write_arbiter_pkg;

  localparam int RN_W   = 5;
  localparam int DATA_W = 32;

  localparam logic [RN_W-1:0] R0_IDX = '0;

  typedef struct packed {
    logic              we;
    logic [RN_W-1:0]   rn;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// Synchronous FIFO buffering auxiliary-unit results until a free write-back slot.
// flush clears pointers and count; stored data is left in place and never observed.
module wb_aux_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int AUX_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [RN_W-1:0]              push_rn,
  input  logic [DATA_W-1:0]            push_data,
  output logic [RN_W-1:0]              head_rn,
  output logic [DATA_W-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(AUX_DEPTH):0]   count
);

  localparam int PW = $clog2(AUX_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;
  logic [RN_W-1:0]   rn_mem   [AUX_DEPTH];
  logic [DATA_W-1:0] data_mem [AUX_DEPTH];

  assign full  = (count_q == CW'(AUX_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign head_rn   = rn_mem[rptr_q];
  assign head_data = data_mem[rptr_q];

  // Self-protecting: an overflow or underflow request is ignored here.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      rn_mem[wptr_q]   <= push_rn;
      data_mem[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port owner: pipeline write-back always wins, buffered aux results
// drain in idle slots. Define WB_STARVE_EN to enable the one-cycle bubble request.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int AUX_DEPTH = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wwreg,
  input  logic [RN_W-1:0]   wrn,
  input  logic [DATA_W-1:0] wr,
  input  logic [DATA_W-1:0] wdo,
  input  logic              wm2reg,
  input  logic              aux_valid,
  input  logic [RN_W-1:0]   aux_rn,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_ready,
  output logic              rf_we,
  output logic [RN_W-1:0]   rf_wn,
  output logic [DATA_W-1:0] rf_wd,
  output logic              aux_pending,
  output logic              stall_req
);

  if (AUX_DEPTH < 2 || (AUX_DEPTH & (AUX_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_write_arbiter: AUX_DEPTH must be a power of two >= 2");
  end
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("wb_write_arbiter: MAX_WAIT must be >= 1");
  end

  logic                       pwr;
  logic [DATA_W-1:0]          pipe_data;
  logic                       aux_push, aux_pop;
  logic                       aux_full, aux_empty;
  logic [RN_W-1:0]            head_rn;
  logic [DATA_W-1:0]          head_data;
  logic [$clog2(AUX_DEPTH):0] aux_count;
  wr_req_t                    rf_q, rf_d;

  wb_aux_fifo #(
    .AUX_DEPTH (AUX_DEPTH)
  ) u_aux_fifo (
    .clk       (clk),
    .flush     (rst),
    .push      (aux_push),
    .pop       (aux_pop),
    .push_rn   (aux_rn),
    .push_data (aux_data),
    .head_rn   (head_rn),
    .head_data (head_data),
    .full      (aux_full),
    .empty     (aux_empty),
    .count     (aux_count)
  );

  // aux_ready/aux_pending derive only from the registered FIFO count.
  assign aux_ready   = !aux_full;
  assign aux_pending = (aux_count != '0);

  // Writes to r0 are architecturally void, so they neither occupy the port nor the FIFO.
  always_comb begin
    pwr       = wwreg && (wrn != R0_IDX);
    pipe_data = wm2reg ? wdo : wr;
    aux_pop   = !pwr && !aux_empty;
    aux_push  = aux_valid && aux_ready && (aux_rn != R0_IDX);
  end

  always_comb begin
    rf_d    = rf_q;
    rf_d.we = 1'b0;
    if (pwr) begin
      rf_d.we   = 1'b1;
      rf_d.rn   = wrn;
      rf_d.data = pipe_data;
    end else if (aux_pop) begin
      rf_d.we   = 1'b1;
      rf_d.rn   = head_rn;
      rf_d.data = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rf_we = rf_q.we;
  assign rf_wn = rf_q.rn;
  assign rf_wd = rf_q.data;

`ifdef WB_STARVE_EN
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;

  // Reaching MAX_WAIT fires the bubble and restarts the count, so it never exceeds MAX_WAIT.
  always_comb begin
    wait_d  = '0;
    stall_d = 1'b0;
    if (!aux_empty && !aux_pop) begin
      if (wait_q >= WW'(MAX_WAIT - 1)) begin
        stall_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_req = stall_q;
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized + directed bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wwreg = 1'b0;
  logic [4:0]        wrn = '0;
  logic [31:0]       wr = '0;
  logic [31:0]       wdo = '0;
  logic              wm2reg = 1'b0;
  logic              aux_valid = 1'b0;
  logic [4:0]        aux_rn = '0;
  logic [31:0]       aux_data = '0;
  logic              aux_ready, rf_we, aux_pending, stall_req;
  logic [4:0]        rf_wn;
  logic [31:0]       rf_wd;

  always #5 clk = ~clk;

  wb_write_arbiter #(.AUX_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .wwreg(wwreg), .wrn(wrn), .wr(wr), .wdo(wdo), .wm2reg(wm2reg),
    .aux_valid(aux_valid), .aux_rn(aux_rn), .aux_data(aux_data), .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_wd(rf_wd), .aux_pending(aux_pending),
    .stall_req(stall_req)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rn;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        e_we = 1'b0;
  logic [4:0]  e_wn = '0;
  logic [31:0] e_wd = '0;
  logic        e_stall = 1'b0;
  int          age = 0;

  // One clock: model consumes the inputs presented this cycle, then outputs are compared.
  task automatic step();
    bit pw, pp;
    int sz;
    @(posedge clk);
    sz = q.size();
    if (rst) begin
      q.delete();
      e_we = 1'b0; e_wn = '0; e_wd = '0; e_stall = 1'b0; age = 0;
    end else begin
      pw = wwreg && (wrn != 0);
      pp = !pw && (sz > 0);
      if (pw) begin
        e_we = 1'b1; e_wn = wrn; e_wd = wm2reg ? wdo : wr;
      end else if (pp) begin
        e_we = 1'b1; e_wn = q[0].rn; e_wd = q[0].d;
      end else begin
        e_we = 1'b0;
      end
`ifdef WB_STARVE_EN
      e_stall = 1'b0;
      if (sz == 0 || pp) age = 0;
      else begin
        age++;
        if (age == MAXW) begin
          e_stall = 1'b1;
          age = 0;
        end
      end
`endif
      if (pp) void'(q.pop_front());
      if (aux_valid && sz != DEPTH && aux_rn != 0) q.push_back('{aux_rn, aux_data});
    end
    #1;
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_wn", 32'(rf_wn), 32'(e_wn));
    chk("rf_wd", rf_wd, e_wd);
    chk("aux_ready", 32'(aux_ready), 32'(q.size() != DEPTH));
    chk("aux_pending", 32'(aux_pending), 32'(q.size() != 0));
    chk("stall_req", 32'(stall_req), 32'(e_stall));
  endtask

  task automatic pipe(input logic w, input logic [4:0] rn, input logic [31:0] a,
                      input logic [31:0] b, input logic m);
    wwreg = w; wrn = rn; wr = a; wdo = b; wm2reg = m;
  endtask

  task automatic aux(input logic v, input logic [4:0] rn, input logic [31:0] d);
    aux_valid = v; aux_rn = rn; aux_data = d;
  endtask

  initial begin
    // Reset with an offered aux result: nothing may be pushed.
    rst = 1'b1;
    aux(1'b1, 5'd3, 32'h3333);
    repeat (3) step();
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_aux_ready", 32'(aux_ready), 32'd1);
    rst = 1'b0;
    aux(1'b0, 5'd0, 32'h0);

    // Pipeline select and r0 suppression.
    pipe(1'b1, 5'd5, 32'h11, 32'h22, 1'b0); step();
    chk("sel_wr", rf_wd, 32'h11);
    pipe(1'b1, 5'd5, 32'h11, 32'h22, 1'b1); step();
    chk("sel_wdo", rf_wd, 32'h22);
    pipe(1'b1, 5'd0, 32'h11, 32'h22, 1'b0); step();
    chk("r0_no_we", 32'(rf_we), 32'd0);
    pipe(1'b0, 5'd0, 32'h0, 32'h0, 1'b0); step();

    // Aux drain with idle pipeline: 2-cycle latency; an r0 entry is discarded.
    aux(1'b1, 5'd7, 32'hABCD); step();
    aux(1'b1, 5'd0, 32'hDEAD); step();
    aux(1'b0, 5'd0, 32'h0); step();
    chk("drain_rn", 32'(rf_wn), 32'd7);
    chk("drain_data", rf_wd, 32'hABCD);
    repeat (2) step();

    // Pipeline holds the port while 5 pushes are offered to a depth-4 FIFO.
    pipe(1'b1, 5'd9, 32'h99, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      aux(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      step();
    end
    chk("full_not_ready", 32'(aux_ready), 32'd0);
    aux(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("order_rn", 32'(rf_wn), 32'(10 + i));
    end
    repeat (2) step();

    // Starvation: one pending entry under continuous pipeline writes, then a bubble.
    aux(1'b1, 5'd21, 32'h5EED); step();
    aux(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd4, 32'h44, 32'h0, 1'b0);
    repeat (12) step();
    pipe(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    repeat (2) step();

    // Simultaneous push/pop at count 2 across 2x depth operations.
    pipe(1'b1, 5'd6, 32'h66, 32'h0, 1'b0);
    aux(1'b1, 5'd1, 32'hA0); step();
    aux(1'b1, 5'd2, 32'hA1); step();
    pipe(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      aux(1'b1, 5'(3 + i), 32'hB0 + 32'(i));
      step();
    end
    aux(1'b0, 5'd0, 32'h0);
    repeat (4) step();

    // Random traffic with varying pipeline load and rare resets.
    for (int ep = 0; ep < 30; ep++) begin
      int load;
      load = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        pipe(($urandom_range(0, 99) < load), 5'($urandom_range(0, 31)), $urandom, $urandom,
             1'($urandom_range(0, 1)));
        aux(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
